// File: rtl/nvme_pcie_pkg.sv
// Shared constants for the NVMe-over-PCIe endpoint: request-type codes,
// CQ tuser bit offsets, the CQ decoder state encoding and the endpoint IDs.
package nvme_pcie_pkg;

  localparam logic [3:0]  MEM_RD = 4'b0000;
  localparam logic [3:0]  MEM_WR = 4'b0001;

  localparam int TUSER_FIRST_BE_LO   = 0;
  localparam int TUSER_LAST_BE_LO    = 4;
  localparam int TUSER_BYTE_EN_LO    = 8;
  localparam int TUSER_SOP           = 40;
  localparam int TUSER_DISCONTINUE   = 41;

  localparam logic [63:0] BAR0         = 64'h0000_0000_F000_0000;
  localparam logic [15:0] REQUESTER_ID = 16'h0100;
  localparam logic [15:0] COMPLETER_ID = 16'h0000;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_HOLD = 3'd1,
    RD_WAIT = 3'd2,
    WR_DATA = 3'd3,
    DROP    = 3'd4
  } cq_state_e;

  // Index of the lowest set bit; an empty mask maps to 0.
  function automatic logic [1:0] lsb4(input logic [3:0] v);
    logic [1:0] r;
    casez (v)
      4'b???1: r = 2'd0;
      4'b??10: r = 2'd1;
      4'b?100: r = 2'd2;
      4'b1000: r = 2'd3;
      default: r = 2'd0;
    endcase
    return r;
  endfunction

  // Index of the highest set bit; an empty mask maps to 0.
  function automatic logic [1:0] msb4(input logic [3:0] v);
    logic [1:0] r;
    casez (v)
      4'b1???: r = 2'd3;
      4'b01??: r = 2'd2;
      4'b001?: r = 2'd1;
      4'b0001: r = 2'd0;
      default: r = 2'd0;
    endcase
    return r;
  endfunction

  // Counter increment that sticks at all-ones.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/be_byte_count.sv
// Combinational byte-count / lower-address calculation for a read request,
// derived from the first/last byte enables and the dword count.
module be_byte_count import nvme_pcie_pkg::*; (
  input  logic [3:0]  first_be,
  input  logic [3:0]  last_be,
  input  logic [10:0] dw_count,
  input  logic [4:0]  addr_hi,
  output logic [12:0] byte_count,
  output logic [6:0]  lower_addr
);

  logic [1:0]  fb_lsb_s;
  logic [1:0]  fb_msb_s;
  logic [1:0]  lb_msb_s;
  logic [12:0] dw_bytes_s;

  assign fb_lsb_s = lsb4(first_be);
  assign fb_msb_s = msb4(first_be);
  assign lb_msb_s = msb4(last_be);

  // Byte count of the request; dword count 0 stands for 1024 dwords.
  always_comb begin
    dw_bytes_s = 13'd0;
    byte_count = 13'd0;
    lower_addr = 7'd0;
    if (dw_count == 11'd0) begin
      dw_bytes_s = 13'd4096;
    end else begin
      dw_bytes_s = {dw_count, 2'b00};
    end
    if (dw_count == 11'd1) begin
      if (first_be == 4'b0000) begin
        byte_count = 13'd1;
      end else begin
        byte_count = {11'd0, fb_msb_s} - {11'd0, fb_lsb_s} + 13'd1;
      end
    end else begin
      byte_count = dw_bytes_s - {11'd0, fb_lsb_s} - (13'd3 - {11'd0, lb_msb_s});
    end
    lower_addr = {addr_hi, fb_lsb_s};
  end

endmodule

// File: rtl/rx_cq_decoder.sv
// Completer-request receive stage: decodes CQ descriptors, issues one held
// read request at a time, streams memory-write beats and drains the rest.
module rx_cq_decoder import nvme_pcie_pkg::*; #(
  parameter int C_DATA_WIDTH        = 128,
  parameter int AXI4_CQ_TUSER_WIDTH = 85,
  parameter int KEEP_WIDTH          = C_DATA_WIDTH / 32,
  parameter int ADDR_W              = 12
) (
  input  logic                           user_clk,
  input  logic                           user_reset_n,
  input  logic                           user_lnk_up,
  input  logic [C_DATA_WIDTH-1:0]        m_axis_cq_tdata,
  input  logic [AXI4_CQ_TUSER_WIDTH-1:0] m_axis_cq_tuser,
  input  logic [KEEP_WIDTH-1:0]          m_axis_cq_tkeep,
  input  logic                           m_axis_cq_tlast,
  input  logic                           m_axis_cq_tvalid,
  output logic [21:0]                    m_axis_cq_tready,
  output logic                           req_valid,
  input  logic                           req_ready,
  output logic [15:0]                    req_requester_id,
  output logic [7:0]                     req_tag,
  output logic [2:0]                     req_tc,
  output logic [2:0]                     req_attr,
  output logic [6:0]                     req_lower_addr,
  output logic [ADDR_W-1:0]              req_addr,
  output logic [10:0]                    req_dw_count,
  output logic [12:0]                    req_byte_count,
  input  logic                           cpl_done,
  output logic                           wr_valid,
  output logic [ADDR_W-1:0]              wr_addr,
  output logic [C_DATA_WIDTH-1:0]        wr_data,
  output logic [15:0]                    wr_be,
  output logic [15:0]                    unsup_cnt
);

  cq_state_e         state_r;
  logic              tready_r;
  logic [ADDR_W-1:0] wr_addr_nxt_r;

  logic              accept_s;
  logic              sop_s;
  logic              disc_s;
  logic [3:0]        req_type_s;
  logic [ADDR_W-1:0] addr_s;
  logic [12:0]       byte_count_s;
  logic [6:0]        lower_addr_s;
  logic              unused_s;

  assign accept_s   = m_axis_cq_tvalid & tready_r;
  assign sop_s      = m_axis_cq_tuser[TUSER_SOP];
  assign disc_s     = m_axis_cq_tuser[TUSER_DISCONTINUE];
  assign req_type_s = m_axis_cq_tdata[78:75];
  assign addr_s     = {m_axis_cq_tdata[ADDR_W-1:2], 2'b00};
  assign m_axis_cq_tready = {22{tready_r}};
  assign unused_s   = ^{m_axis_cq_tkeep, m_axis_cq_tuser[AXI4_CQ_TUSER_WIDTH-1:42],
                        m_axis_cq_tuser[39:24]};

  be_byte_count u_be_byte_count (
    .first_be   (m_axis_cq_tuser[TUSER_FIRST_BE_LO +: 4]),
    .last_be    (m_axis_cq_tuser[TUSER_LAST_BE_LO +: 4]),
    .dw_count   (m_axis_cq_tdata[74:64]),
    .addr_hi    (m_axis_cq_tdata[6:2]),
    .byte_count (byte_count_s),
    .lower_addr (lower_addr_s)
  );

  // Decoder FSM with all outputs registered; link-down is a synchronous flush.
  always_ff @(posedge user_clk or negedge user_reset_n) begin
    if (!user_reset_n) begin
      state_r          <= IDLE;
      tready_r         <= 1'b0;
      wr_addr_nxt_r    <= '0;
      req_valid        <= 1'b0;
      req_requester_id <= 16'd0;
      req_tag          <= 8'd0;
      req_tc           <= 3'd0;
      req_attr         <= 3'd0;
      req_lower_addr   <= 7'd0;
      req_addr         <= '0;
      req_dw_count     <= 11'd0;
      req_byte_count   <= 13'd0;
      wr_valid         <= 1'b0;
      wr_addr          <= '0;
      wr_data          <= '0;
      wr_be            <= 16'd0;
      unsup_cnt        <= 16'd0;
    end else if (!user_lnk_up) begin
      state_r          <= IDLE;
      tready_r         <= 1'b0;
      wr_addr_nxt_r    <= '0;
      req_valid        <= 1'b0;
      req_requester_id <= 16'd0;
      req_tag          <= 8'd0;
      req_tc           <= 3'd0;
      req_attr         <= 3'd0;
      req_lower_addr   <= 7'd0;
      req_addr         <= '0;
      req_dw_count     <= 11'd0;
      req_byte_count   <= 13'd0;
      wr_valid         <= 1'b0;
      wr_addr          <= '0;
      wr_data          <= '0;
      wr_be            <= 16'd0;
      unsup_cnt        <= 16'd0;
    end else begin
      wr_valid <= 1'b0;
      case (state_r)
        IDLE: begin
          tready_r <= 1'b1;
          if (accept_s && sop_s) begin
            case (req_type_s)
              MEM_RD: begin
                if (m_axis_cq_tlast) begin
                  req_requester_id <= m_axis_cq_tdata[95:80];
                  req_tag          <= m_axis_cq_tdata[103:96];
                  req_tc           <= m_axis_cq_tdata[123:121];
                  req_attr         <= m_axis_cq_tdata[126:124];
                  req_lower_addr   <= lower_addr_s;
                  req_addr         <= addr_s;
                  req_dw_count     <= m_axis_cq_tdata[74:64];
                  req_byte_count   <= byte_count_s;
                  req_valid        <= 1'b1;
                  tready_r         <= 1'b0;
                  state_r          <= RD_HOLD;
                end else begin
                  unsup_cnt <= sat_inc16(unsup_cnt);
                  state_r   <= DROP;
                end
              end
              MEM_WR: begin
                wr_addr       <= addr_s;
                wr_addr_nxt_r <= addr_s;
                state_r       <= WR_DATA;
              end
              default: begin
                unsup_cnt <= sat_inc16(unsup_cnt);
                if (!m_axis_cq_tlast) begin
                  state_r <= DROP;
                end
              end
            endcase
          end
        end
        RD_HOLD: begin
          if (req_ready) begin
            req_valid <= 1'b0;
            state_r   <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (cpl_done) begin
            tready_r <= 1'b1;
            state_r  <= IDLE;
          end
        end
        WR_DATA: begin
          if (accept_s) begin
            if (disc_s) begin
              unsup_cnt <= sat_inc16(unsup_cnt);
              state_r   <= m_axis_cq_tlast ? IDLE : DROP;
            end else begin
              wr_valid      <= 1'b1;
              wr_data       <= m_axis_cq_tdata;
              wr_be         <= m_axis_cq_tuser[TUSER_BYTE_EN_LO +: 16];
              wr_addr       <= wr_addr_nxt_r;
              wr_addr_nxt_r <= wr_addr_nxt_r + {{(ADDR_W-5){1'b0}}, 5'd16};
              if (m_axis_cq_tlast) begin
                state_r <= IDLE;
              end
            end
          end
        end
        DROP: begin
          if (accept_s && m_axis_cq_tlast) begin
            state_r <= IDLE;
          end
        end
        default: begin
          tready_r <= 1'b1;
          state_r  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rx_cq_decoder.sv
// Self-checking bench for rx_cq_decoder: read requests and write beats are
// predicted into scoreboard queues and compared when the DUT emits them.
module tb_rx_cq_decoder;

  logic          user_clk;
  logic          user_reset_n;
  logic          user_lnk_up;
  logic [127:0]  m_axis_cq_tdata;
  logic [84:0]   m_axis_cq_tuser;
  logic [3:0]    m_axis_cq_tkeep;
  logic          m_axis_cq_tlast;
  logic          m_axis_cq_tvalid;
  logic [21:0]   m_axis_cq_tready;
  logic          req_valid;
  logic          req_ready;
  logic [15:0]   req_requester_id;
  logic [7:0]    req_tag;
  logic [2:0]    req_tc;
  logic [2:0]    req_attr;
  logic [6:0]    req_lower_addr;
  logic [11:0]   req_addr;
  logic [10:0]   req_dw_count;
  logic [12:0]   req_byte_count;
  logic          cpl_done;
  logic          wr_valid;
  logic [11:0]   wr_addr;
  logic [127:0]  wr_data;
  logic [15:0]   wr_be;
  logic [15:0]   unsup_cnt;

  typedef struct packed {
    logic [15:0] rid;
    logic [7:0]  tag;
    logic [2:0]  tc;
    logic [2:0]  attr;
    logic [6:0]  lower;
    logic [11:0] addr;
    logic [10:0] dw;
    logic [12:0] bc;
  } rd_exp_t;

  typedef struct packed {
    logic [11:0]  addr;
    logic [127:0] data;
    logic [15:0]  be;
  } wr_exp_t;

  localparam logic [21:0] TREADY_ON = 22'h3FFFFF;

  rd_exp_t rd_q[$];
  wr_exp_t wr_q[$];
  rd_exp_t rd_got, rd_e;
  wr_exp_t wr_got, wr_e;
  logic    req_valid_d;
  int      checks;
  int      errors;
  int      cyc;
  logic [15:0] exp_unsup;

  rx_cq_decoder dut (
    .user_clk         (user_clk),
    .user_reset_n     (user_reset_n),
    .user_lnk_up      (user_lnk_up),
    .m_axis_cq_tdata  (m_axis_cq_tdata),
    .m_axis_cq_tuser  (m_axis_cq_tuser),
    .m_axis_cq_tkeep  (m_axis_cq_tkeep),
    .m_axis_cq_tlast  (m_axis_cq_tlast),
    .m_axis_cq_tvalid (m_axis_cq_tvalid),
    .m_axis_cq_tready (m_axis_cq_tready),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_requester_id (req_requester_id),
    .req_tag          (req_tag),
    .req_tc           (req_tc),
    .req_attr         (req_attr),
    .req_lower_addr   (req_lower_addr),
    .req_addr         (req_addr),
    .req_dw_count     (req_dw_count),
    .req_byte_count   (req_byte_count),
    .cpl_done         (cpl_done),
    .wr_valid         (wr_valid),
    .wr_addr          (wr_addr),
    .wr_data          (wr_data),
    .wr_be            (wr_be),
    .unsup_cnt        (unsup_cnt)
  );

  initial user_clk = 1'b0;
  always #5 user_clk = ~user_clk;

  always @(posedge user_clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard monitor: compares each new read request and each write beat.
  always @(negedge user_clk) begin
    if (req_valid && !req_valid_d) begin
      checks <= checks + 1;
      rd_got = {req_requester_id, req_tag, req_tc, req_attr, req_lower_addr,
                req_addr, req_dw_count, req_byte_count};
      if (rd_q.size() == 0) begin
        errors <= errors + 1;
        $display("FAIL rd_unexpected got=%h", rd_got);
      end else begin
        rd_e = rd_q.pop_front();
        if (rd_got !== rd_e) begin
          errors <= errors + 1;
          $display("FAIL rd_fields got=%h exp=%h", rd_got, rd_e);
        end
      end
    end
    req_valid_d <= req_valid;
    if (wr_valid) begin
      checks <= checks + 1;
      wr_got = {wr_addr, wr_data, wr_be};
      if (wr_q.size() == 0) begin
        errors <= errors + 1;
        $display("FAIL wr_unexpected got=%h", wr_got);
      end else begin
        wr_e = wr_q.pop_front();
        if (wr_got !== wr_e) begin
          errors <= errors + 1;
          $display("FAIL wr_beat got=%h exp=%h", wr_got, wr_e);
        end
      end
    end
  end

  function automatic logic [127:0] mk_desc(input logic [63:0] addr, input logic [10:0] dw,
                                           input logic [3:0] typ, input logic [15:0] rid,
                                           input logic [7:0] tag, input logic [2:0] tc,
                                           input logic [2:0] attr);
    logic [127:0] d;
    d = 128'd0;
    d[63:0]    = addr;
    d[74:64]   = dw;
    d[78:75]   = typ;
    d[95:80]   = rid;
    d[103:96]  = tag;
    d[123:121] = tc;
    d[126:124] = attr;
    return d;
  endfunction

  function automatic logic [84:0] mk_user(input logic [3:0] fb, input logic [3:0] lb,
                                          input logic [15:0] be, input logic sop,
                                          input logic disc);
    logic [84:0] u;
    u = 85'd0;
    u[3:0]  = fb;
    u[7:4]  = lb;
    u[23:8] = be;
    u[40]   = sop;
    u[41]   = disc;
    return u;
  endfunction

  // Present one beat at a negedge and hold it until tready lets it through.
  task automatic send_beat(input logic [127:0] d, input logic [84:0] u, input logic last);
    int n;
    m_axis_cq_tdata  = d;
    m_axis_cq_tuser  = u;
    m_axis_cq_tlast  = last;
    m_axis_cq_tvalid = 1'b1;
    n = 0;
    while (m_axis_cq_tready[0] !== 1'b1 && n < 50) begin
      @(negedge user_clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL send_timeout tready=%h required=%h", m_axis_cq_tready, TREADY_ON);
    end
    @(negedge user_clk);
    m_axis_cq_tvalid = 1'b0;
    m_axis_cq_tlast  = 1'b0;
  endtask

  task automatic do_read(input logic [127:0] d, input logic [84:0] u, input rd_exp_t e,
                         input bit complete);
    rd_q.push_back(e);
    send_beat(d, u, 1'b1);
    checks++;
    if (req_valid !== 1'b1 || m_axis_cq_tready !== 22'd0) begin
      errors++;
      $display("FAIL rd_latency req_valid=%b tready=%h required 1/0", req_valid, m_axis_cq_tready);
    end
    cpl_done = 1'b1;
    @(negedge user_clk);
    cpl_done = 1'b0;
    checks++;
    if (req_valid !== 1'b1) begin
      errors++;
      $display("FAIL rd_early_cpl req_valid=%b required 1", req_valid);
    end
    @(negedge user_clk);
    req_ready = 1'b1;
    @(negedge user_clk);
    req_ready = 1'b0;
    checks++;
    if (req_valid !== 1'b0 || m_axis_cq_tready !== 22'd0) begin
      errors++;
      $display("FAIL rd_wait req_valid=%b tready=%h required 0/0", req_valid, m_axis_cq_tready);
    end
    if (complete) begin
      repeat (2) @(negedge user_clk);
      cpl_done = 1'b1;
      @(negedge user_clk);
      cpl_done = 1'b0;
      checks++;
      if (m_axis_cq_tready !== TREADY_ON) begin
        errors++;
        $display("FAIL rd_done tready=%h required %h", m_axis_cq_tready, TREADY_ON);
      end
    end
  endtask

  task automatic check_unsup(input string name);
    @(negedge user_clk);
    checks++;
    if (unsup_cnt !== exp_unsup) begin
      errors++;
      $display("FAIL %s unsup_cnt=%0d required %0d", name, unsup_cnt, exp_unsup);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge user_clk);
    checks++;
    if ({m_axis_cq_tready, req_valid, wr_valid, unsup_cnt} !== 40'd0) begin
      errors++;
      $display("FAIL reset_outputs tready=%h req_valid=%b wr_valid=%b unsup=%h required 0",
               m_axis_cq_tready, req_valid, wr_valid, unsup_cnt);
    end
    user_reset_n = 1'b1;
    @(negedge user_clk);
    checks++;
    if (m_axis_cq_tready !== TREADY_ON) begin
      errors++;
      $display("FAIL reset_release tready=%h required %h", m_axis_cq_tready, TREADY_ON);
    end
  endtask

  task automatic test_memrd();
    do_read(mk_desc(64'h1000_0040, 11'd16, 4'b0000, 16'h0100, 8'h05, 3'd2, 3'd1),
            mk_user(4'hF, 4'hF, 16'h0000, 1'b1, 1'b0),
            '{16'h0100, 8'h05, 3'd2, 3'd1, 7'h40, 12'h040, 11'd16, 13'd64}, 1'b1);
    do_read(mk_desc(64'h124, 11'd1, 4'b0000, 16'hABCD, 8'h7E, 3'd0, 3'd4),
            mk_user(4'b0110, 4'h0, 16'h0000, 1'b1, 1'b0),
            '{16'hABCD, 8'h7E, 3'd0, 3'd4, 7'h25, 12'h124, 11'd1, 13'd2}, 1'b1);
  endtask

  task automatic test_rd_boundary();
    do_read(mk_desc(64'hF80, 11'd0, 4'b0000, 16'h0200, 8'h11, 3'd7, 3'd7),
            mk_user(4'hF, 4'hF, 16'h0000, 1'b1, 1'b0),
            '{16'h0200, 8'h11, 3'd7, 3'd7, 7'h00, 12'hF80, 11'd0, 13'd4096}, 1'b1);
    do_read(mk_desc(64'h204, 11'd2, 4'b0000, 16'h0300, 8'h22, 3'd1, 3'd2),
            mk_user(4'b1000, 4'b0001, 16'h0000, 1'b1, 1'b0),
            '{16'h0300, 8'h22, 3'd1, 3'd2, 7'h07, 12'h204, 11'd2, 13'd2}, 1'b1);
  endtask

  task automatic test_memwr();
    logic [127:0] d0, d1;
    d0 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    d1 = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;
    wr_q.push_back('{12'h008, d0, 16'hFFFF});
    wr_q.push_back('{12'h018, d1, 16'hFFFF});
    send_beat(mk_desc(64'h8, 11'd8, 4'b0001, 16'h0100, 8'h00, 3'd0, 3'd0),
              mk_user(4'hF, 4'hF, 16'h0000, 1'b1, 1'b0), 1'b0);
    send_beat(d0, mk_user(4'h0, 4'h0, 16'hFFFF, 1'b0, 1'b0), 1'b0);
    send_beat(d1, mk_user(4'h0, 4'h0, 16'hFFFF, 1'b0, 1'b0), 1'b1);
    @(negedge user_clk);
    checks++;
    if (wr_q.size() != 0) begin
      errors++;
      $display("FAIL memwr_pending left=%0d required 0", wr_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int c0;
    logic [127:0] da, db;
    da = 128'hAAAA_0000_BBBB_1111_CCCC_2222_DDDD_3333;
    db = 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321;
    wr_q.push_back('{12'h100, da, 16'hFFFF});
    wr_q.push_back('{12'h200, db, 16'h00FF});
    c0 = cyc;
    send_beat(mk_desc(64'h100, 11'd4, 4'b0001, 16'h0100, 8'h00, 3'd0, 3'd0),
              mk_user(4'hF, 4'hF, 16'h0000, 1'b1, 1'b0), 1'b0);
    send_beat(da, mk_user(4'h0, 4'h0, 16'hFFFF, 1'b0, 1'b0), 1'b1);
    send_beat(mk_desc(64'h200, 11'd2, 4'b0001, 16'h0100, 8'h00, 3'd0, 3'd0),
              mk_user(4'hF, 4'hF, 16'h0000, 1'b1, 1'b0), 1'b0);
    send_beat(db, mk_user(4'h0, 4'h0, 16'h00FF, 1'b0, 1'b0), 1'b1);
    checks++;
    if (cyc - c0 != 4) begin
      errors++;
      $display("FAIL back_to_back cycles=%0d required 4", cyc - c0);
    end
    @(negedge user_clk);
    checks++;
    if (wr_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_pending left=%0d required 0", wr_q.size());
    end
  endtask

  task automatic test_unsupported();
    send_beat(mk_desc(64'h40, 11'd4, 4'b0010, 16'h0100, 8'h01, 3'd0, 3'd0),
              mk_user(4'hF, 4'hF, 16'h0000, 1'b1, 1'b0), 1'b0);
    send_beat(128'h5555, mk_user(4'h0, 4'h0, 16'hFFFF, 1'b0, 1'b0), 1'b1);
    exp_unsup = exp_unsup + 16'd1;
    check_unsup("unsup_type");
    send_beat(mk_desc(64'h40, 11'd1, 4'b0000, 16'h0100, 8'h01, 3'd0, 3'd0),
              mk_user(4'h0, 4'h0, 16'h0000, 1'b0, 1'b0), 1'b1);
    check_unsup("non_sop_idle");
    send_beat(mk_desc(64'h40, 11'd1, 4'b0000, 16'h0100, 8'h01, 3'd0, 3'd0),
              mk_user(4'hF, 4'h0, 16'h0000, 1'b1, 1'b0), 1'b0);
    send_beat(128'h6666, mk_user(4'h0, 4'h0, 16'hFFFF, 1'b0, 1'b0), 1'b1);
    exp_unsup = exp_unsup + 16'd1;
    check_unsup("malformed_rd");
  endtask

  task automatic test_discontinue();
    logic [127:0] dn;
    dn = 128'hCAFE_F00D_0000_0000_0000_0000_0000_0077;
    send_beat(mk_desc(64'h300, 11'd12, 4'b0001, 16'h0100, 8'h00, 3'd0, 3'd0),
              mk_user(4'hF, 4'hF, 16'h0000, 1'b1, 1'b0), 1'b0);
    send_beat(128'h1, mk_user(4'h0, 4'h0, 16'hFFFF, 1'b0, 1'b1), 1'b0);
    send_beat(128'h2, mk_user(4'h0, 4'h0, 16'hFFFF, 1'b0, 1'b0), 1'b0);
    send_beat(128'h3, mk_user(4'h0, 4'h0, 16'hFFFF, 1'b0, 1'b0), 1'b1);
    exp_unsup = exp_unsup + 16'd1;
    check_unsup("discontinue");
    wr_q.push_back('{12'h040, dn, 16'h0F0F});
    send_beat(mk_desc(64'h40, 11'd4, 4'b0001, 16'h0100, 8'h00, 3'd0, 3'd0),
              mk_user(4'hF, 4'hF, 16'h0000, 1'b1, 1'b0), 1'b0);
    send_beat(dn, mk_user(4'h0, 4'h0, 16'h0F0F, 1'b0, 1'b0), 1'b1);
    @(negedge user_clk);
    checks++;
    if (wr_q.size() != 0) begin
      errors++;
      $display("FAIL disc_next_tlp left=%0d required 0", wr_q.size());
    end
  endtask

  task automatic test_link_down();
    user_lnk_up = 1'b0;
    @(negedge user_clk);
    checks++;
    if (unsup_cnt !== 16'd0 || m_axis_cq_tready !== 22'd0) begin
      errors++;
      $display("FAIL link_down unsup=%h tready=%h required 0/0", unsup_cnt, m_axis_cq_tready);
    end
    exp_unsup = 16'd0;
    user_lnk_up = 1'b1;
    @(negedge user_clk);
    checks++;
    if (m_axis_cq_tready !== TREADY_ON) begin
      errors++;
      $display("FAIL link_up tready=%h required %h", m_axis_cq_tready, TREADY_ON);
    end
  endtask

  task automatic test_mid_reset();
    exp_unsup = exp_unsup + 16'd1;
    send_beat(mk_desc(64'h0, 11'd1, 4'b0100, 16'h0100, 8'h00, 3'd0, 3'd0),
              mk_user(4'hF, 4'h0, 16'h0000, 1'b1, 1'b0), 1'b1);
    check_unsup("pre_reset_unsup");
    do_read(mk_desc(64'h1000_0040, 11'd16, 4'b0000, 16'h0100, 8'h05, 3'd2, 3'd1),
            mk_user(4'hF, 4'hF, 16'h0000, 1'b1, 1'b0),
            '{16'h0100, 8'h05, 3'd2, 3'd1, 7'h40, 12'h040, 11'd16, 13'd64}, 1'b0);
    #2;
    user_reset_n = 1'b0;
    #1;
    checks++;
    if ({m_axis_cq_tready, req_valid, req_requester_id, req_tag, req_byte_count,
         req_lower_addr, wr_valid, wr_addr, unsup_cnt} !== 97'd0) begin
      errors++;
      $display("FAIL mid_reset tready=%h req_valid=%b rid=%h tag=%h bc=%h unsup=%h required 0",
               m_axis_cq_tready, req_valid, req_requester_id, req_tag, req_byte_count, unsup_cnt);
    end
    exp_unsup = 16'd0;
    @(negedge user_clk);
    user_reset_n = 1'b1;
    @(negedge user_clk);
    checks++;
    if (m_axis_cq_tready !== TREADY_ON) begin
      errors++;
      $display("FAIL post_reset_tready tready=%h required %h", m_axis_cq_tready, TREADY_ON);
    end
    do_read(mk_desc(64'h0000_0010, 11'd3, 4'b0000, 16'h0042, 8'h99, 3'd3, 3'd0),
            mk_user(4'b1100, 4'b0011, 16'h0000, 1'b1, 1'b0),
            '{16'h0042, 8'h99, 3'd3, 3'd0, 7'h12, 12'h010, 11'd3, 13'd8}, 1'b1);
  endtask

  initial begin
    checks           = 0;
    errors           = 0;
    cyc              = 0;
    exp_unsup        = 16'd0;
    req_valid_d      = 1'b0;
    user_reset_n     = 1'b0;
    user_lnk_up      = 1'b1;
    m_axis_cq_tdata  = 128'd0;
    m_axis_cq_tuser  = 85'd0;
    m_axis_cq_tkeep  = 4'hF;
    m_axis_cq_tlast  = 1'b0;
    m_axis_cq_tvalid = 1'b0;
    req_ready        = 1'b0;
    cpl_done         = 1'b0;

    test_reset();
    test_memrd();
    test_rd_boundary();
    test_memwr();
    test_back_to_back();
    test_unsupported();
    test_discontinue();
    test_link_down();
    test_mid_reset();

    repeat (2) @(negedge user_clk);
    checks++;
    if (rd_q.size() != 0 || wr_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain rd_left=%0d wr_left=%0d required 0", rd_q.size(), wr_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
